// File: rtl/hashed_weight_mac.sv
// Hashed-weight MAC: codebook lookup by centroid index, signed multiply, row accumulation,
// and a 2-entry first-word-fall-through FIFO for completed row sums.
module hashed_weight_mac #(
  parameter int unsigned ACT_W   = 16,
  parameter int unsigned CB_W    = 16,
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned ROW_LEN = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cb_wr_en,
  input  logic [4:0]              cb_wr_addr,
  input  logic signed [CB_W-1:0]  cb_wr_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              in_centroid,
  input  logic signed [ACT_W-1:0] in_act,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic [15:0]             row_count
);

  localparam int unsigned PROD_W   = CB_W + ACT_W;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned CB_DEPTH = 32;

  logic signed [CB_W-1:0]   codebook [CB_DEPTH];
  logic [CNT_W-1:0]         beat_cnt;
  logic                     accept;
  logic                     beat_last;

  logic                     s1_valid;
  logic                     s1_last;
  logic signed [CB_W-1:0]   s1_weight;
  logic signed [ACT_W-1:0]  s1_act;

  logic                     s2_valid;
  logic                     s2_last;
  logic signed [PROD_W-1:0] s2_prod;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;

  logic                     push;
  logic                     pop;
  logic [1:0]               fifo_count;
  logic [1:0]               count_nxt;
  logic signed [ACC_W-1:0]  fifo_tail;
  logic signed [ACC_W-1:0]  head_nxt;
  logic signed [ACC_W-1:0]  tail_nxt;
  logic [1:0]               lif;

  // Rows whose last beat is in flight reserve a FIFO slot, so the FIFO can never overflow.
  assign lif      = 2'(s1_valid & s1_last) + 2'(s2_valid & s2_last);
  assign in_ready = (3'(fifo_count) + 3'(lif)) < 3'd2;
  assign accept   = in_valid & in_ready;
  assign beat_last = (beat_cnt == CNT_W'(ROW_LEN - 1));

  // Codebook: a same-cycle lookup sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) codebook[i] <= '0;
    end else if (cb_wr_en) begin
      codebook[cb_wr_addr] <= cb_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_last ? '0 : beat_cnt + CNT_W'(1);
    end
  end

  // S1: lookup and operand capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_weight <= '0;
      s1_act    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_weight <= codebook[in_centroid];
        s1_act    <= in_act;
        s1_last   <= beat_last;
      end
    end
  end

  // S2: exact signed product.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_prod  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod <= PROD_W'(s1_weight) * PROD_W'(s1_act);
        s2_last <= s1_last;
      end
    end
  end

  // S3: wrapping accumulate; the last beat's total goes to the FIFO and the row restarts at 0.
  assign acc_sum = acc + ACC_W'(s2_prod);
  assign push    = s2_valid & s2_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (s2_valid) begin
      acc <= s2_last ? '0 : acc_sum;
    end
  end

  assign pop = out_valid & out_ready;

  // FIFO next state; the head register doubles as out_sum and keeps the last popped value.
  always_comb begin
    count_nxt = fifo_count;
    head_nxt  = out_sum;
    tail_nxt  = fifo_tail;
    if (push && !pop) begin
      count_nxt = fifo_count + 2'd1;
      if (fifo_count == 2'd0) head_nxt = acc_sum;
      else                    tail_nxt = acc_sum;
    end else if (!push && pop) begin
      count_nxt = fifo_count - 2'd1;
      if (fifo_count == 2'd2) head_nxt = fifo_tail;
    end else if (push && pop) begin
      if (fifo_count == 2'd2) begin
        head_nxt = fifo_tail;
        tail_nxt = acc_sum;
      end else begin
        head_nxt = acc_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_count <= '0;
      out_sum    <= '0;
      fifo_tail  <= '0;
      out_valid  <= 1'b0;
    end else begin
      fifo_count <= count_nxt;
      out_sum    <= head_nxt;
      fifo_tail  <= tail_nxt;
      out_valid  <= (count_nxt != 2'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_count <= '0;
    end else if (pop) begin
      row_count <= row_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hashed_weight_mac.sv
// Bench for hashed_weight_mac: directed scenarios plus random traffic, scored against a
// row-level reference model (codebook array, running sum, queue of expected row sums).
module tb_hashed_weight_mac;

  localparam int ROW_LEN = 4;

  logic               clk;
  logic               rst;
  logic               cb_wr_en;
  logic [4:0]         cb_wr_addr;
  logic signed [15:0] cb_wr_data;
  logic               in_valid;
  logic               in_ready;
  logic [4:0]         in_centroid;
  logic signed [15:0] in_act;
  logic               out_valid;
  logic               out_ready;
  logic signed [39:0] out_sum;
  logic [15:0]        row_count;

  int total = 0;
  int bad   = 0;

  logic signed [15:0] cb_m [32];
  logic signed [39:0] acc_m;
  int                 cnt_m;
  logic [15:0]        rows_m;
  logic signed [39:0] exp_q [$];

  hashed_weight_mac #(
    .ACT_W(16), .CB_W(16), .ACC_W(40), .ROW_LEN(ROW_LEN)
  ) dut (
    .clk(clk), .rst(rst),
    .cb_wr_en(cb_wr_en), .cb_wr_addr(cb_wr_addr), .cb_wr_data(cb_wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_centroid(in_centroid), .in_act(in_act),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .row_count(row_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: decides at mid-cycle what the coming edge will do.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cb_m[i] = '0;
      acc_m  = '0;
      cnt_m  = 0;
      rows_m = '0;
      exp_q.delete();
    end else begin
      check("in_ready", in_ready, exp_q.size() < 2);
      if (exp_q.size() == 0) check("idle_valid", out_valid, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) begin
          check("sum", out_sum, exp_q[0]);
          void'(exp_q.pop_front());
        end
        check("row_count", row_count, rows_m);
        rows_m = rows_m + 16'd1;
      end
      if (in_valid && in_ready) begin
        acc_m = acc_m + 40'(longint'(cb_m[in_centroid]) * longint'(in_act));
        if (cnt_m == ROW_LEN - 1) begin
          exp_q.push_back(acc_m);
          acc_m = '0;
          cnt_m = 0;
        end else begin
          cnt_m++;
        end
      end
      if (cb_wr_en) cb_m[cb_wr_addr] = cb_wr_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic signed [15:0] d);
    cb_wr_en = 1'b1; cb_wr_addr = a; cb_wr_data = d;
    tick();
    cb_wr_en = 1'b0;
  endtask

  task automatic send(input logic [4:0] c, input logic signed [15:0] a);
    int n = 0;
    in_valid = 1'b1; in_centroid = c; in_act = a;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic signed [39:0] exp);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check(tag, out_sum, exp);
    tick();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      tick();
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cb_wr_en = 1'b0; cb_wr_addr = '0; cb_wr_data = '0;
    in_valid = 1'b0; in_centroid = '0; in_act = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_row_count", row_count, 0);
    check("rst_in_ready", in_ready, 1);
    tick();

    // Codebook load and single row, with latency check.
    wr(5'd3, 16'sd5);
    wr(5'd7, -16'sd2);
    send(5'd3, 16'sd10);
    send(5'd7, 16'sd4);
    send(5'd3, -16'sd1);
    send(5'd7, 16'sd0);
    @(negedge clk);
    check("t1_lat0", out_valid, 0);
    @(negedge clk);
    check("t1_lat1", out_valid, 0);
    @(negedge clk);
    check("t1_lat2", out_valid, 1);
    check("t1_sum", out_sum, 40'sd37);
    tick();
    @(negedge clk);
    check("t1_rows", row_count, 1);
    tick();

    // Back-to-back rows with a bubble.
    wr(5'd0, 16'sd1);
    send(5'd0, 16'sd1);
    send(5'd0, 16'sd1);
    tick();
    send(5'd0, 16'sd1);
    send(5'd0, 16'sd1);
    for (int i = 0; i < 4; i++) send(5'd0, 16'sd1);
    drain("t2_drain");
    @(negedge clk);
    check("t2_rows", row_count, 3);
    tick();

    // Backpressure: two rows fill the FIFO, third row waits.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(5'd0, 16'sd1);
    @(negedge clk);
    check("t3_ready_low", in_ready, 0);
    repeat (4) @(negedge clk);
    check("t3_head_valid", out_valid, 1);
    check("t3_head_sum", out_sum, 40'sd4);
    check("t3_still_blocked", in_ready, 0);
    tick();
    fork
      begin
        for (int i = 0; i < 4; i++) send(5'd0, 16'sd1);
      end
      begin
        repeat (3) tick();
        out_ready = 1'b1;
      end
    join
    drain("t3_drain");

    // Write/lookup collision returns the old value.
    wr(5'd9, 16'sd1);
    cb_wr_en = 1'b1; cb_wr_addr = 5'd9; cb_wr_data = 16'sd100;
    send(5'd9, 16'sd1);
    cb_wr_en = 1'b0;
    send(5'd9, 16'sd1);
    send(5'd0, 16'sd0);
    send(5'd0, 16'sd0);
    wait_out("t4_sum", 40'sd101);

    // Signed extremes.
    wr(5'd1, -16'sd32768);
    for (int i = 0; i < 4; i++) send(5'd1, -16'sd32768);
    wait_out("t5_pos", 40'sh0100000000);
    wr(5'd2, -16'sd32768);
    for (int i = 0; i < 4; i++) send(5'd2, 16'sd32767);
    wait_out("t5_neg", -40'sd4294836224);

    // Reset mid-row.
    send(5'd2, 16'sd1);
    send(5'd2, 16'sd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_valid", out_valid, 0);
    check("t6_rows", row_count, 0);
    check("t6_ready", in_ready, 1);
    tick();
    send(5'd3, 16'sd7);
    send(5'd3, 16'sd7);
    wr(5'd3, 16'sd2);
    send(5'd3, 16'sd7);
    send(5'd3, 16'sd7);
    wait_out("t6_sum", 40'sd28);

    // Random traffic with concurrent codebook writes and one reset.
    for (int i = 0; i < 32; i++) wr(5'(i), 16'($urandom));
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_centroid = 5'($urandom);
      case ($urandom_range(0, 3))
        0:       in_act = -16'sd32768;
        1:       in_act = 16'sd32767;
        default: in_act = 16'($urandom);
      endcase
      cb_wr_en   = ($urandom_range(0, 7) == 0);
      cb_wr_addr = 5'($urandom);
      cb_wr_data = 16'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      rst        = (cyc == 200);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; cb_wr_en = 1'b0;
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hashed_weight_mac.md
Name: hashed_weight_mac

Overview:
- Consumer stage directly downstream of the XXhash centroid generator in the hashed-weight datapath.
- Each valid beat carries a 5-bit centroid index and an activation.
- The block looks up the shared weight value in a 32-entry codebook, multiplies it by the activation, and accumulates over ROW_LEN beats.
- Each completed row sum is emitted through a 2-entry output FIFO with valid/ready handshake. Codebook is loaded via a write port.

Parameters:
- ACT_W, 16, signed activation width
- CB_W, 16, signed codebook (centroid value) width
- ACC_W, 40, signed accumulator / row-sum width
- ROW_LEN, 64, beats per row; legal range 4..65535

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high (already decided)
- cb_wr_en  in  1  codebook write strobe
- cb_wr_addr  in  5  codebook entry index
- cb_wr_data  in  CB_W  signed codebook value
- in_valid  in  1  beat valid; upstream delays the activation to align it with the centroid
- in_ready  out  1  beat accepted when in_valid && in_ready; upstream sequencer holds its indices while low
- in_centroid  in  5  centroid index from hash stage
- in_act  in  ACT_W  signed activation
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accept
- out_sum  out  ACC_W  signed row sum at FIFO head
- row_count  out  16  number of rows popped since reset, wraps at 2^16

Behaviour:
- Reset values: codebook all 0; pipeline valids 0; beat counter 0; accumulator 0; FIFO empty; out_valid 0; out_sum 0; row_count 0; in_ready 1 (first cycle after reset).
- Codebook write: cb_wr_en writes cb_wr_data at the rising edge.
  - Writes are accepted regardless of in_valid.
  - A lookup in the same cycle as a write to the same address returns the OLD value; the new value is visible from the next cycle.
- Pipeline (accepted beat, cycle 0 = accept edge):
  - S1 (edge 0): register codebook[in_centroid], in_act, and a last flag. last = (beat counter == ROW_LEN-1).
  - S2 (edge 1): register signed product, CB_W+ACT_W bits, exact.
  - S3 (edge 2): accumulate. The product is sign-extended to ACC_W and added modulo 2^ACC_W (wraps, no saturation).
    - On a last beat, the value written to the FIFO is acc+product, and the accumulator is cleared to 0 in the same edge.
    - The next row's first beat therefore starts from 0.
  - A row sum becomes visible on out_valid/out_sum 3 cycles after its last beat is accepted, if the FIFO was empty.
- Beat counter: increments on each accepted beat; wraps ROW_LEN-1 -> 0. Bubbles (in_valid=0) do not advance the counter or accumulator.
- FIFO: 2 entries, first-word fall-through.
  - out_sum holds the head value; when empty it holds the last popped value (0 after reset).
  - Pop on out_valid && out_ready; row_count increments on each pop.
  - Push and pop in the same cycle with the FIFO full is legal; count stays 2.
- Flow control:
  - lif = number of last beats in S1..S3 not yet pushed (0 or 1, since ROW_LEN >= 4).
  - in_ready = (fifo_count + lif) < 2, combinational from registered state only; no combinational path from out_ready.
  - This guarantees FIFO overflow is impossible. The hash stage is never stalled by this block; upstream is responsible for holding indices.
- in_valid while in_ready=0: beat is ignored, no state change.
- rst mid-row: partial accumulation and in-flight beats are discarded, the FIFO is flushed, and the codebook is cleared.

Test Plan:
1. Codebook load and single row:
   - Stimulus: ROW_LEN=4; write cb[3]=5, cb[7]=-2; beats (3,10),(7,4),(3,-1),(7,0); out_ready=1.
   - Response: out_valid pulses 3 cycles after the 4th beat with out_sum=50-8-5+0=37; row_count=1.
2. Back-to-back rows with bubbles:
   - Stimulus: two rows of 4 beats of (idx 0, act 1) with cb[0]=1, an idle cycle inserted mid-row 1.
   - Response: two sums of 4, no carry-over between rows.
3. Backpressure:
   - Stimulus: out_ready=0; stream 3 rows of 4 beats of cb=1, act=1.
   - Response: FIFO holds 4,4; in_ready drops once the second last beat is accepted; no third sum is lost; releasing out_ready drains both, then the third row completes with sum 4.
4. Write/read collision:
   - Stimulus: cb[9]=1; in the same cycle write cb[9]=100 and accept beat (9,1); next beat (9,1).
   - Response: contributions 1 then 100.
5. Signed extremes and wrap:
   - Stimulus: ROW_LEN=4; cb=-32768, act=-32768 for all 4 beats.
   - Response: out_sum = 4*2^30 = 0x0100000000 exactly; a negative-only row yields a correctly sign-extended negative sum.
6. Reset mid-row:
   - Stimulus: 2 beats accepted, rst for 1 cycle, then a full row with cb reloaded.
   - Response: after reset out_valid=0, codebook reads 0 until rewritten, and the first sum reflects only post-reset beats.
